decoder_scan_ctrl: RTL and testbench

Scan sequencer directly upstream of the 2-to-4 decoder. It generates the decoder's `in` (select) and `en` inputs, stepping through the four decoder outputs with a programmable dwell per channel and a fixed blanking gap between channels. Typical use is display-digit or row multiplexing. It supports single-pass and continuous modes, a per-channel skip mask, and per-window strobes for downstream logic.

---
 rtl/decoder_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - scan sequencer generating select and enable for a 2-to-4 decoder
//
// Purpose: steps sel through the enabled decoder channels, holding en high for a
// latched dwell per channel with a fixed en-low blanking gap between windows.
// Ports:
//   clk, rst     single clock, synchronous active-high reset
//   start        begin a scan (sampled only in IDLE)
//   stop         abort a scan (sampled only while busy)
//   mode         0 = continuous, 1 = single pass (latched on accepted start)
//   dwell        en-high cycles per channel, 0 treated as 1 (latched on accepted start)
//   ch_mask      per-channel enable, bit i enables channel i (latched on accepted start)
//   sel, en      decoder select and enable
//   busy         scan in progress (ACTIVE or BLANK)
//   ch_strobe    pulse on the first cycle of each channel window
//   done         pulse when a single-pass scan completes
module decoder_scan_ctrl #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         ch_mask,
    output logic [1:0]         sel,
    output logic               en,
    output logic               busy,
    output logic               ch_strobe,
    output logic               done
);

    localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               ch_strobe_q, ch_strobe_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BW-1:0]      blank_cnt_q, blank_cnt_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
    logic [3:0]         mask_q, mask_d;

    logic accept;
    logic window_end;
    logic blank_end;
    logic advance;
    logic last_ch;
    logic enter_win;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Upward search from cur+1 with wrap; reaching cur itself (k=4) lets a
    // single enabled channel re-select itself.
    function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] c;
        r = cur;
        for (int k = 4; k >= 1; k--) begin
            c = cur + 2'(k);
            if (m[c]) r = c;
        end
        return r;
    endfunction

    function automatic logic is_highest(input logic [1:0] cur, input logic [3:0] m);
        logic h;
        h = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if ((i > int'(cur)) && m[i]) h = 1'b0;
        end
        return h;
    endfunction

    assign accept     = start && (ch_mask != 4'd0);
    assign window_end = (state_q == S_ACTIVE) && (dwell_cnt_q == dwell_lat_q - DWELL_W'(1));
    assign blank_end  = (BLANK_CYC > 0) && (state_q == S_BLANK) && (blank_cnt_q == BLANK_LAST);
    // With no blanking gap the channel step happens straight out of ACTIVE.
    assign advance    = (BLANK_CYC == 0) ? window_end : blank_end;
    assign last_ch    = mode_q && is_highest(sel_q, mask_q);
    assign enter_win  = (state_d == S_ACTIVE) && ((state_q != S_ACTIVE) || advance);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop takes priority over any window or blank completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (stop)            state_d = S_IDLE;
                else if (advance)    state_d = last_ch ? S_IDLE : S_ACTIVE;
                else if (window_end) state_d = S_BLANK;
            end
            S_BLANK: begin
                if (stop)         state_d = S_IDLE;
                else if (advance) state_d = last_ch ? S_IDLE : S_ACTIVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: registered outputs are computed from the upcoming state.
    always_comb begin
        en_d        = (state_d == S_ACTIVE);
        busy_d      = (state_d != S_IDLE);
        ch_strobe_d = enter_win;
        done_d      = advance && last_ch && !stop;
        sel_d       = sel_q;
        if ((state_q == S_IDLE) && accept) begin
            sel_d = lowest_idx(ch_mask);
        end else if (enter_win) begin
            sel_d = next_idx(sel_q, mask_q);
        end
    end

    // Dwell/blank counters and start-time parameter latches.
    always_comb begin
        dwell_cnt_d = '0;
        blank_cnt_d = '0;
        mode_d      = mode_q;
        dwell_lat_d = dwell_lat_q;
        mask_d      = mask_q;
        if ((state_q == S_ACTIVE) && (state_d == S_ACTIVE) && !advance) begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
        end
        if ((state_q == S_BLANK) && (state_d == S_BLANK)) begin
            blank_cnt_d = blank_cnt_q + BW'(1);
        end
        if ((state_q == S_IDLE) && accept) begin
            mode_d      = mode;
            dwell_lat_d = (dwell == '0) ? DWELL_W'(1) : dwell;
            mask_d      = ch_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= 2'd0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            ch_strobe_q <= 1'b0;
            done_q      <= 1'b0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
            mode_q      <= 1'b0;
            dwell_lat_q <= DWELL_W'(1);
            mask_q      <= 4'd0;
        end else begin
            sel_q       <= sel_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            ch_strobe_q <= ch_strobe_d;
            done_q      <= done_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            mode_q      <= mode_d;
            dwell_lat_q <= dwell_lat_d;
            mask_q      <= mask_d;
        end
    end

    assign sel       = sel_q;
    assign en        = en_q;
    assign busy      = busy_q;
    assign ch_strobe = ch_strobe_q;
    assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - self-checking bench for decoder_scan_ctrl
module tb_decoder_scan_ctrl;

    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] dwell;
    logic [3:0] ch_mask;
    logic [1:0] sel;
    logic       en;
    logic       busy;
    logic       ch_strobe;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(B)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
        .ch_mask   (ch_mask),
        .sel       (sel),
        .en        (en),
        .busy      (busy),
        .ch_strobe (ch_strobe),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s t=%0d observed={sel,en,busy,strb,done}=%b expected=%b", tag, t, obs[5:0], exp[5:0]);
    endtask

    // Expected outputs t cycles after the accepting edge (t=1 is the first window
    // cycle), derived from the channel list, the period D+B and the mode.
    function automatic void model(input int t, input bit md, input int d, input logic [3:0] m,
                                  output logic [1:0] s, output logic e, output logic b,
                                  output logic st, output logic dn);
        int lst[4];
        int n, dd, p, k, ph;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                lst[n] = i;
                n++;
            end
        end
        dd = (d == 0) ? 1 : d;
        p  = dd + B;
        k  = (t - 1) / p;
        ph = (t - 1) % p;
        if (md && (k >= n)) begin
            s  = 2'(lst[n-1]);
            e  = 1'b0;
            b  = 1'b0;
            st = 1'b0;
            dn = (t == n * p + 1);
        end else begin
            s  = 2'(lst[k % n]);
            e  = (ph < dd);
            b  = 1'b1;
            st = (ph == 0);
            dn = 1'b0;
        end
    endfunction

    task automatic run_scan(input string tag, input bit md, input logic [7:0] d, input logic [3:0] m,
                            input int ncyc, input int stop_at, input bit noise, input bit stop_w_start);
        logic [1:0] s, s_hold;
        logic       e, b, st, dn, b_hold;
        s_hold  = 2'd0;
        b_hold  = 1'b0;
        mode    = md;
        dwell   = d;
        ch_mask = m;
        start   = 1'b1;
        stop    = stop_w_start;
        step();
        start = 1'b0;
        stop  = 1'b0;
        for (int t = 1; t <= ncyc; t++) begin
            model(t, md, int'(d), m, s, e, b, st, dn);
            if ((stop_at > 0) && (t == stop_at)) begin
                s_hold = s;
                b_hold = b;
            end
            if ((stop_at > 0) && (t > stop_at) && b_hold) begin
                s  = s_hold;
                e  = 1'b0;
                b  = 1'b0;
                st = 1'b0;
                dn = 1'b0;
            end
            chk(tag, t, {2'b00, sel, en, busy, ch_strobe, done}, {2'b00, s, e, b, st, dn});
            if (t < ncyc) begin
                stop = (t == stop_at);
                if (noise && b) begin
                    start   = 1'($urandom_range(0, 1));
                    mode    = 1'($urandom_range(0, 1));
                    dwell   = 8'($urandom);
                    ch_mask = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
                step();
            end
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        bit         md;
        logic [7:0] d;
        logic [3:0] m;
        int         n, p, ncyc, sa;

        rst     = 1'b1;
        start   = 1'b1;
        stop    = 1'b0;
        mode    = 1'b1;
        dwell   = 8'd3;
        ch_mask = 4'hF;

        // Reset held for three cycles with start asserted
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset", i, {2'b00, sel, en, busy, ch_strobe, done}, 8'h00);
        end
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("post_reset_idle", 0, {2'b00, sel, en, busy, ch_strobe, done}, 8'h00);

        // start with an empty mask is ignored
        ch_mask = 4'h0;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("empty_mask", 1, {2'b00, sel, en, busy, ch_strobe, done}, 8'h00);
        step();
        chk("empty_mask", 2, {2'b00, sel, en, busy, ch_strobe, done}, 8'h00);

        // Single pass, full mask, dwell 3: done on the cycle after the last blank
        run_scan("single_full", 1'b1, 8'd3, 4'hF, 4 * (3 + B) + 1, 0, 1'b0, 1'b0);
        // Continuous skip mask 1010 started on the done cycle
        run_scan("skip_wrap", 1'b0, 8'd2, 4'b1010, 19, 18, 1'b0, 1'b0);
        // dwell 0 behaves as 1
        run_scan("dwell_zero", 1'b1, 8'd0, 4'hF, 4 * (1 + B) + 1, 0, 1'b0, 1'b0);
        // stop in the second ACTIVE cycle of channel 2
        run_scan("stop_mid", 1'b0, 8'd3, 4'hF, 13, 2 * (3 + B) + 2, 1'b0, 1'b0);
        // fresh start resumes from the lowest enabled channel
        run_scan("restart", 1'b1, 8'd1, 4'hF, 4 * (1 + B) + 1, 0, 1'b0, 1'b0);
        // start pulses and input changes while busy are ignored
        run_scan("ignored_inputs", 1'b1, 8'd3, 4'hF, 4 * (3 + B) + 1, 0, 1'b1, 1'b0);
        // start and stop together in IDLE: start wins
        run_scan("start_stop_idle", 1'b1, 8'd1, 4'b0100, 1 * (1 + B) + 1, 0, 1'b0, 1'b1);

        // Reset in the middle of a scan on channel 3
        run_scan("pre_reset", 1'b1, 8'd5, 4'b1000, 3, 0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk("mid_scan_reset", 0, {2'b00, sel, en, busy, ch_strobe, done}, 8'h00);
        rst = 1'b0;
        step();
        chk("mid_scan_reset_idle", 1, {2'b00, sel, en, busy, ch_strobe, done}, 8'h00);

        // Randomized scans against the reference model
        for (int r = 0; r < 40; r++) begin
            md = 1'($urandom_range(0, 1));
            d  = 8'($urandom_range(0, 4));
            m  = 4'($urandom_range(1, 15));
            n  = $countones(m);
            p  = ((d == 0) ? 1 : int'(d)) + B;
            if (md) begin
                ncyc = n * p + 1;
                sa   = 0;
                if ($urandom_range(0, 2) == 0) begin
                    sa   = $urandom_range(1, n * p);
                    ncyc = sa + 1;
                end
            end else begin
                sa   = $urandom_range(1, 3 * n * p);
                ncyc = sa + 1;
            end
            run_scan("random", md, d, m, ncyc, sa, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
